// File: rtl/cmac_pkg.sv
// cmac_pkg: shared widths and feeder state encoding for the cmac slice.
// Imported by the feeder, its pair FIFO, cmac and the layer controller.
package cmac_pkg;

  localparam int FP16_W  = 16;
  localparam int CMAC_AW = 10;
  localparam int CMAC_LW = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT,
    ST_DONE
  } feed_state_e;

endpackage

// File: rtl/pair_fifo.sv
// pair_fifo: 2-entry show-ahead FIFO of {data,weight} pairs.
// clk/rst_n, flush_i, push_i/wdata_i, pop_i, head_o (current head), count_o.
module pair_fifo
  import cmac_pkg::*;
#(
  parameter int W = 2 * FP16_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem0_q;
  logic [W-1:0] mem1_q;
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  // A push into a full FIFO is only taken when the head leaves
  // in the same cycle; the freed slot is the one being written.
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        if (wr_ptr_q) begin
          mem1_q <= wdata_i;
        end else begin
          mem0_q <= wdata_i;
        end
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_o  = rd_ptr_q ? mem1_q : mem0_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/cmac_feeder.sv
// cmac_feeder: reads data/weight pairs from two sync-read buffers and
// streams them to cmac (data_valid/ready), brackets the job with
// conv_valid/conv_ready, captures result into result_q, pulses done.
// Job: start/len/data_base/weight_base -> busy/done/err/result_q.
// Buffers: *_rd_en/*_rd_addr out, *_rd_q in (1-cycle latency).
// cmac: conv_valid/conv_ready, data_valid/data_ready, data/weight, result.
module cmac_feeder
  import cmac_pkg::*;
#(
  parameter int DW = FP16_W,
  parameter int AW = CMAC_AW,
  parameter int LW = CMAC_LW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic [AW-1:0] data_base,
  input  logic [AW-1:0] weight_base,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] result_q,
  output logic          data_rd_en,
  output logic [AW-1:0] data_rd_addr,
  input  logic [DW-1:0] data_rd_q,
  output logic          weight_rd_en,
  output logic [AW-1:0] weight_rd_addr,
  input  logic [DW-1:0] weight_rd_q,
  output logic          conv_valid,
  input  logic          conv_ready,
  output logic          data_valid,
  input  logic          data_ready,
  output logic [DW-1:0] data,
  output logic [DW-1:0] weight,
  input  logic [DW-1:0] result
);

  feed_state_e state_q, state_d;

  logic [LW-1:0]   len_q;
  logic [AW-1:0]   dbase_q;
  logic [AW-1:0]   wbase_q;
  logic [LW-1:0]   issued_q, issued_d;
  logic [LW-1:0]   sent_q, sent_d;
  logic            infl_q, infl_d;
  logic            err_q, err_d;
  logic [DW-1:0]   res_d;

  logic            issue;
  logic            flush;
  logic            fifo_pop;
  logic            last_pop;
  logic            abort;
  logic            room;
  logic [1:0]      fifo_cnt;
  logic [2:0]      occ;
  logic [2*DW-1:0] head;
  logic [AW-1:0]   daddr;
  logic [AW-1:0]   waddr;

  // The word read last cycle is on *_rd_q now: push it unconditionally.
  pair_fifo #(
    .W(2 * DW)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst),
    .flush_i(flush),
    .push_i (infl_q),
    .wdata_i({data_rd_q, weight_rd_q}),
    .pop_i  (fifo_pop),
    .head_o (head),
    .count_o(fifo_cnt)
  );

  assign data_valid = (fifo_cnt != 2'd0);
  assign fifo_pop   = data_valid && data_ready;
  assign {data, weight} = head;

  // Slots that will be committed after this edge; keeping this below
  // two means a returning word always finds space.
  assign occ  = {1'b0, fifo_cnt} + {2'b00, infl_q} - {2'b00, fifo_pop};
  assign room = (occ < 3'd2);

  assign last_pop = fifo_pop && ((sent_q + LW'(1)) == len_q);
  assign abort    = (state_q == ST_RUN) && conv_ready && !last_pop;

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    sent_d   = sent_q;
    infl_d   = 1'b0;
    err_d    = err_q;
    res_d    = result_q;
    issue    = 1'b0;
    flush    = 1'b0;
    daddr    = '0;
    waddr    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          issued_d = '0;
          sent_d   = '0;
          err_d    = 1'b0;
          if (len != '0) begin
            // First read goes out with start to save a cycle.
            issue    = 1'b1;
            daddr    = data_base;
            waddr    = weight_base;
            issued_d = LW'(1);
            infl_d   = 1'b1;
            state_d  = ST_RUN;
          end else begin
            state_d  = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          flush   = 1'b1;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          if (fifo_pop) begin
            sent_d = sent_q + LW'(1);
          end
          if (last_pop) begin
            state_d = ST_WAIT;
          end
          if ((issued_q < len_q) && room) begin
            issue    = 1'b1;
            daddr    = dbase_q + AW'(issued_q);
            waddr    = wbase_q + AW'(issued_q);
            issued_d = issued_q + LW'(1);
            infl_d   = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (conv_ready) begin
          res_d   = result;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      dbase_q  <= '0;
      wbase_q  <= '0;
      issued_q <= '0;
      sent_q   <= '0;
      infl_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      sent_q   <= sent_d;
      infl_q   <= infl_d;
      err_q    <= err_d;
      result_q <= res_d;
      if ((state_q == ST_IDLE) && start) begin
        len_q   <= len;
        dbase_q <= data_base;
        wbase_q <= weight_base;
      end
    end
  end

  assign busy           = (state_q == ST_RUN) || (state_q == ST_WAIT);
  assign conv_valid     = busy;
  assign done           = (state_q == ST_DONE);
  assign err            = done && err_q;
  assign data_rd_en     = issue;
  assign weight_rd_en   = issue;
  assign data_rd_addr   = daddr;
  assign weight_rd_addr = waddr;

endmodule
